// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter and occupancy guard for a shared FIFO.
// Grants one producer per cycle while not full, and gates reads while empty.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 256,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic                      fifo_write_en,
  input  logic                      rd_req,
  output logic                      fifo_read_en,
  output logic                      rd_valid,
  output logic                      rd_err,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             found;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Search starts just after the last served producer; rst_n gating keeps
  // every strobe low while reset is held, independent of the flops.
  always_comb begin
    req_ready    = '0;
    fifo_data_in = '0;
    grant_idx    = '0;
    sel_idx      = '0;
    found        = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && !full && rst_n && req_valid[sel_idx]) begin
        found              = 1'b1;
        grant_idx          = sel_idx;
        req_ready[sel_idx] = 1'b1;
        fifo_data_in       = req_data[sel_idx*DATA_W +: DATA_W];
      end
    end
  end

  assign fifo_write_en = found;
  assign fifo_read_en  = rd_req & ~empty & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      count    <= count + CNT_W'(fifo_write_en) - CNT_W'(fifo_read_en);
      rd_valid <= fifo_read_en;
      rd_err   <= rd_req & empty;
      if (fifo_write_en) begin
        last_grant <= grant_idx;
      end
    end
  end

endmodule
